// File: rtl/rt_de_stream_tx_pkg.sv
// Shared types and default sizes for the DE-stream transmitter and its paired CDC sender.
package rt_cdc_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int CWIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rt_de_stream_tx_if.sv
// Upstream stream plus CDC-sender handshake bundle for rt_de_stream_tx.
interface rt_de_stream_tx_if import rt_cdc_pkg::*; #(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CWIDTH = CWIDTH_DEF
) ();

    logic                      rt_i_valid;
    logic                      rt_o_ready;
    logic [DWIDTH-1:0]         rt_i_data;
    logic                      rt_o_de;
    logic [DWIDTH-1:0]         rt_o_din;
    logic                      rt_i_busy;
    logic [lvl_w(DEPTH)-1:0]   rt_o_level;
    logic [CWIDTH-1:0]         rt_o_xfer_cnt;

    modport master (
        output rt_i_valid, rt_i_data, rt_i_busy,
        input  rt_o_ready, rt_o_de, rt_o_din, rt_o_level, rt_o_xfer_cnt
    );

    modport slave (
        input  rt_i_valid, rt_i_data, rt_i_busy,
        output rt_o_ready, rt_o_de, rt_o_din, rt_o_level, rt_o_xfer_cnt
    );

endinterface

// File: rtl/rt_de_stream_tx_fifo.sv
// Single-clock FIFO with synchronous reset and occupancy output; head word is visible on dout.
module rt_sync_fifo import rt_cdc_pkg::*; #(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DWIDTH-1:0]        din,
    input  logic                     pop,
    output logic [DWIDTH-1:0]        dout,
    output logic [lvl_w(DEPTH)-1:0]  count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rt_de_stream_tx.sv
// Buffers upstream words and feeds them one at a time to a single-word CDC sender via de/busy.
//   state | meaning
//   IDLE  | nothing in flight; launch head word once busy is low
//   SEND  | de high, din held; the first edge with busy low is the acceptance
//   WAIT  | post-acceptance; first cycle ignores busy, then launch next or return to IDLE
module rt_de_stream_tx import rt_cdc_pkg::*; #(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CWIDTH = CWIDTH_DEF
) (
    input  logic               rt_i_clk,
    input  logic               rt_i_rst,
    rt_de_stream_tx_if.slave   bus
);
    localparam int LW = lvl_w(DEPTH);

    state_t            state;
    logic              wait_first;
    logic              rst_done;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DWIDTH-1:0] head;
    logic [LW-1:0]     level;

    // rst_done keeps ready low through reset and raises it on the first edge after release.
    assign bus.rt_o_ready = rst_done & ~full;
    assign bus.rt_o_level = level;
    assign push           = bus.rt_i_valid & bus.rt_o_ready;

    always_comb begin
        pop = 1'b0;
        if (!empty && !bus.rt_i_busy) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if (state == WAIT && !wait_first) begin
                pop = 1'b1;
            end
        end
    end

    rt_sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (rt_i_clk),
        .rst   (rt_i_rst),
        .push  (push),
        .din   (bus.rt_i_data),
        .pop   (pop),
        .dout  (head),
        .count (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge rt_i_clk) begin
        if (rt_i_rst) begin
            state             <= IDLE;
            wait_first        <= 1'b0;
            rst_done          <= 1'b0;
            bus.rt_o_de       <= 1'b0;
            bus.rt_o_din      <= '0;
            bus.rt_o_xfer_cnt <= '0;
        end else begin
            rst_done <= 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.rt_o_din <= head;
                        bus.rt_o_de  <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (!bus.rt_i_busy) begin
                        bus.rt_o_de       <= 1'b0;
                        bus.rt_o_xfer_cnt <= bus.rt_o_xfer_cnt + CWIDTH'(1);
                        wait_first        <= 1'b1;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    wait_first <= 1'b0;
                    if (pop) begin
                        bus.rt_o_din <= head;
                        bus.rt_o_de  <= 1'b1;
                        state        <= SEND;
                    end else if (!wait_first && !bus.rt_i_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus.rt_o_de <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rt_de_stream_tx.sv
// Directed bench for rt_de_stream_tx: DEPTH=4, DWIDTH=8, CWIDTH=4 so the counter wrap is reachable.
module tb_rt_de_stream_tx;
    import rt_cdc_pkg::*;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rt_de_stream_tx_if #(.DWIDTH(DW), .DEPTH(DP), .CWIDTH(CW)) bus ();

    rt_de_stream_tx #(.DWIDTH(DW), .DEPTH(DP), .CWIDTH(CW)) dut (
        .rt_i_clk (clk),
        .rt_i_rst (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Acceptance edge (busy low), then busy high for one cycle, then busy low for one edge.
    task automatic finish_word(input int exp_cnt);
        tick();
        chk("acc_de", 32'(bus.rt_o_de), 32'd0);
        chk("acc_cnt", 32'(bus.rt_o_xfer_cnt), 32'(exp_cnt));
        bus.rt_i_busy = 1'b1;
        tick();
        chk("gap_de", 32'(bus.rt_o_de), 32'd0);
        bus.rt_i_busy = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] fill_data [5];
        checks = 0;
        errors = 0;
        fill_data[0] = 8'h11; fill_data[1] = 8'h22; fill_data[2] = 8'h33;
        fill_data[3] = 8'h44; fill_data[4] = 8'h55;

        rst            = 1'b1;
        bus.rt_i_valid = 1'b0;
        bus.rt_i_data  = '0;
        bus.rt_i_busy  = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_level", 32'(bus.rt_o_level), 32'd0);
        chk("rst_de", 32'(bus.rt_o_de), 32'd0);
        chk("rst_din", 32'(bus.rt_o_din), 32'd0);
        chk("rst_cnt", 32'(bus.rt_o_xfer_cnt), 32'd0);
        chk("rst_ready", 32'(bus.rt_o_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(bus.rt_o_ready), 32'd1);

        // Single word 0xA5: de one edge after push
        bus.rt_i_valid = 1'b1;
        bus.rt_i_data  = 8'hA5;
        tick();
        bus.rt_i_valid = 1'b0;
        chk("single_level", 32'(bus.rt_o_level), 32'd1);
        chk("single_de0", 32'(bus.rt_o_de), 32'd0);
        tick();
        chk("single_de", 32'(bus.rt_o_de), 32'd1);
        chk("single_din", 32'(bus.rt_o_din), 32'hA5);
        chk("single_pop_level", 32'(bus.rt_o_level), 32'd0);
        tick();
        chk("single_acc_de", 32'(bus.rt_o_de), 32'd0);
        chk("single_cnt", 32'(bus.rt_o_xfer_cnt), 32'd1);
        bus.rt_i_busy = 1'b1;
        tick();
        tick();
        tick();
        chk("single_wait_st", 32'(dut.state), 32'(WAIT));
        bus.rt_i_busy = 1'b0;
        tick();
        chk("single_idle_st", 32'(dut.state), 32'(IDLE));
        chk("single_cnt_hold", 32'(bus.rt_o_xfer_cnt), 32'd1);

        // Fill with busy high: 5th word refused
        bus.rt_i_busy  = 1'b1;
        bus.rt_i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.rt_i_data = fill_data[i];
            tick();
        end
        bus.rt_i_valid = 1'b0;
        chk("fill_level", 32'(bus.rt_o_level), 32'd4);
        chk("fill_ready", 32'(bus.rt_o_ready), 32'd0);
        chk("fill_de", 32'(bus.rt_o_de), 32'd0);
        bus.rt_i_busy = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("fill_out_de", 32'(bus.rt_o_de), 32'd1);
            chk("fill_out_din", 32'(bus.rt_o_din), 32'(fill_data[k]));
            chk("fill_out_level", 32'(bus.rt_o_level), 32'(3 - k));
            chk("fill_ready_back", 32'(bus.rt_o_ready), 32'd1);
            finish_word(2 + k);
        end
        chk("fill_end_de", 32'(bus.rt_o_de), 32'd0);
        chk("fill_end_st", 32'(dut.state), 32'(IDLE));

        // Stall in SEND
        bus.rt_i_valid = 1'b1;
        bus.rt_i_data  = 8'h5C;
        tick();
        bus.rt_i_valid = 1'b0;
        tick();
        chk("stall_de_start", 32'(bus.rt_o_de), 32'd1);
        bus.rt_i_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_de", 32'(bus.rt_o_de), 32'd1);
            chk("stall_din", 32'(bus.rt_o_din), 32'h5C);
            chk("stall_cnt", 32'(bus.rt_o_xfer_cnt), 32'd5);
        end
        bus.rt_i_busy = 1'b0;
        finish_word(6);
        tick();
        chk("stall_one_inc", 32'(bus.rt_o_xfer_cnt), 32'd6);

        // Simultaneous push and pop at level 2
        bus.rt_i_busy  = 1'b1;
        bus.rt_i_valid = 1'b1;
        bus.rt_i_data  = 8'h61;
        tick();
        bus.rt_i_data  = 8'h62;
        tick();
        chk("pp_level_pre", 32'(bus.rt_o_level), 32'd2);
        bus.rt_i_data  = 8'h63;
        bus.rt_i_busy  = 1'b0;
        tick();
        bus.rt_i_valid = 1'b0;
        chk("pp_level", 32'(bus.rt_o_level), 32'd2);
        chk("pp_din0", 32'(bus.rt_o_din), 32'h61);
        finish_word(7);
        chk("pp_din1", 32'(bus.rt_o_din), 32'h62);
        chk("pp_level1", 32'(bus.rt_o_level), 32'd1);
        finish_word(8);
        chk("pp_din2", 32'(bus.rt_o_din), 32'h63);
        finish_word(9);
        chk("pp_end_st", 32'(dut.state), 32'(IDLE));

        // Reset while in WAIT with three words buffered
        bus.rt_i_valid = 1'b1;
        bus.rt_i_data  = 8'h71;
        tick();
        bus.rt_i_data  = 8'h72;
        tick();
        chk("rw_din", 32'(bus.rt_o_din), 32'h71);
        bus.rt_i_data  = 8'h73;
        tick();
        bus.rt_i_busy  = 1'b1;
        bus.rt_i_data  = 8'h74;
        tick();
        bus.rt_i_valid = 1'b0;
        chk("rw_level", 32'(bus.rt_o_level), 32'd3);
        chk("rw_state", 32'(dut.state), 32'(WAIT));
        chk("rw_cnt", 32'(bus.rt_o_xfer_cnt), 32'd10);
        rst = 1'b1;
        tick();
        chk("rw_rst_level", 32'(bus.rt_o_level), 32'd0);
        chk("rw_rst_de", 32'(bus.rt_o_de), 32'd0);
        chk("rw_rst_cnt", 32'(bus.rt_o_xfer_cnt), 32'd0);
        chk("rw_rst_ready", 32'(bus.rt_o_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("rw_ready", 32'(bus.rt_o_ready), 32'd1);
        bus.rt_i_valid = 1'b1;
        bus.rt_i_data  = 8'h81;
        tick();
        bus.rt_i_valid = 1'b0;
        tick();
        tick();
        chk("rw_hold_de", 32'(bus.rt_o_de), 32'd0);
        chk("rw_hold_level", 32'(bus.rt_o_level), 32'd1);
        bus.rt_i_busy = 1'b0;
        tick();
        chk("rw_launch_de", 32'(bus.rt_o_de), 32'd1);
        chk("rw_launch_din", 32'(bus.rt_o_din), 32'h81);
        finish_word(1);

        // Counter wrap: 17 transfers from reset with a 4-bit counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            bus.rt_i_valid = 1'b1;
            bus.rt_i_data  = 8'(8'h90 + i);
            tick();
            bus.rt_i_valid = 1'b0;
            tick();
            chk("wrap_de", 32'(bus.rt_o_de), 32'd1);
            chk("wrap_din", 32'(bus.rt_o_din), 32'(8'h90 + i));
            finish_word((i + 1) % 16);
        end
        chk("wrap_final", 32'(bus.rt_o_xfer_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
